// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave receiver slice.
package spi_pkg;

  localparam int SPI_WORD_W = 8;

  localparam logic [SPI_WORD_W-1:0] TX_IDLE_DEFAULT = 8'h00;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one SPI pin plus a history flop that yields
// single-cycle rise/fall strobes in the clk domain.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      hist  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI mode-0 slave: oversampled pins, MOSI deserialiser, one-word tx buffer feeding MISO.
// Optional SPI_SLAVE_FRAME_ERR_EN adds a frame_err pulse output.
//
// state | meaning
// IDLE  | CS high; MISO parked low, bit counter cleared
// SHIFT | frame active; bits move on synchronised SCLK edges
module spi_slave_receiver
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_WORD_W,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE     = DATA_WIDTH'(TX_IDLE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [0:0]      ST_IDLE  = IDLE;
  localparam logic [0:0]      ST_SHIFT = SHIFT;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_fall, cs_rise_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(SCLK),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(CS),
    .level(cs_s), .rise(cs_rise_unused), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(MOSI),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic [0:0]            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_in;
  logic [DATA_WIDTH-1:0] shift_out;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_full;
  logic                  miso_q;

  logic                  in_shift, abort, start, boundary, load, unload, accept, buf_full_next;
  logic [DATA_WIDTH-1:0] load_word, rx_word;

  // CS high overrides any SCLK edge seen in the same cycle.
  assign in_shift      = (state == ST_SHIFT);
  assign abort         = in_shift & cs_s;
  assign start         = ~in_shift & cs_fall;
  assign boundary      = in_shift & ~cs_s & sclk_fall & (bit_cnt == '0);
  assign load          = start | boundary;
  assign unload        = load & buf_full;
  assign accept        = tx_valid & tx_ready;
  assign buf_full_next = (buf_full & ~unload) | accept;
  assign load_word     = buf_full ? buf_data : TX_IDLE;
  assign rx_word       = {shift_in[DATA_WIDTH-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
      tx_ready    <= 1'b1;
      miso_q      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      buf_full    <= buf_full_next;
      tx_ready    <= ~buf_full_next;
      if (accept) buf_data <= tx_data;

      if (abort) begin
        state    <= ST_IDLE;
        bit_cnt  <= '0;
        shift_in <= '0;
        miso_q   <= 1'b0;
      end else if (start) begin
        state       <= ST_SHIFT;
        bit_cnt     <= '0;
        shift_out   <= load_word;
        miso_q      <= load_word[DATA_WIDTH-1];
        tx_underrun <= ~buf_full;
      end else if (in_shift) begin
        if (sclk_rise) begin
          shift_in <= rx_word;
          if (bit_cnt == LAST_BIT) begin
            rx_data  <= rx_word;
            rx_valid <= 1'b1;
            bit_cnt  <= '0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        if (sclk_fall) begin
          if (boundary) begin
            shift_out   <= load_word;
            miso_q      <= load_word[DATA_WIDTH-1];
            tx_underrun <= ~buf_full;
          end else begin
            shift_out <= shift_out << 1;
            miso_q    <= shift_out[DATA_WIDTH-2];
          end
        end
      end else begin
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end
    end
  end

  assign MISO = miso_q;
  assign busy = in_shift;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= (abort & (bit_cnt != '0)) | (~in_shift & (sclk_rise | sclk_fall));
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Directed bench for spi_slave_receiver: the bench plays SPI master (SCLK = clk/8).
module tb_spi_slave_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       SCLK, CS, MOSI;
  logic       MISO;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int         rx_cnt = 0;
  int         urun_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] rx_log [0:63];

  always #5 clk = ~clk;

  spi_slave_receiver dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[5:0]] = rx_data;
      rx_cnt++;
    end
    if (tx_underrun) urun_cnt++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (frame_err) ferr_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bit ok;
    wait_ready(ok);
    check("push_ready", 32'(ok), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Mode 0 master: data changes while SCLK is low, MISO captured at the rising edge.
  // When stop is set, CS rises together with the last falling edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit start,
                      input bit stop, output logic [7:0] mi);
    mi = '0;
    if (start) CS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[7-i];
      tick(4);
      SCLK = 1'b1;
      mi = {mi[6:0], MISO};
      tick(4);
      SCLK = 1'b0;
      if (stop && i == nbits - 1) CS = 1'b1;
    end
    if (stop) tick(6);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"}, 32'(MISO), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m0, m1;
    int rx0, ur0, fe0;
    bit ok;

    rst = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(4);
    check_reset_vals("rst");

    // 1: single word, preloaded tx
    push(8'b1000_0011);
    check("t1_ready_full", 32'(tx_ready), 32'd0);
    rx0 = rx_cnt; ur0 = urun_cnt;
    fork
      xfer(8'b1110_0010, 8, 1'b1, 1'b1, m0);
      begin
        tick(8);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready_start", 32'(tx_ready), 32'd1);
      end
    join
    check("t1_rx_data", 32'(rx_data), 32'hE2);
    check("t1_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    check("t1_miso", 32'(m0), 32'h83);
    check("t1_underrun", 32'(urun_cnt - ur0), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: back-to-back words, second tx word loaded mid-frame
    push(8'hA5);
    rx0 = rx_cnt; ur0 = urun_cnt;
    fork
      begin
        xfer(8'h11, 8, 1'b1, 1'b0, m0);
        xfer(8'h22, 8, 1'b0, 1'b1, m1);
      end
      begin
        tick(6);
        push(8'h3C);
      end
    join
    check("t2_rx_cnt", 32'(rx_cnt - rx0), 32'd2);
    check("t2_rx_w0", 32'(rx_log[rx0[5:0]]), 32'h11);
    check("t2_rx_w1", 32'(rx_log[6'(rx0 + 1)]), 32'h22);
    check("t2_miso_w0", 32'(m0), 32'hA5);
    check("t2_miso_w1", 32'(m1), 32'h3C);
    check("t2_underrun", 32'(urun_cnt - ur0), 32'd0);

    // 3: nothing buffered
    rx0 = rx_cnt; ur0 = urun_cnt;
    CS = 1'b0;
    tick(4);
    check("t3_underrun_start", 32'(urun_cnt - ur0), 32'd1);
    xfer(8'hFF, 8, 1'b1, 1'b1, m0);
    check("t3_underrun", 32'(urun_cnt - ur0), 32'd1);
    check("t3_miso", 32'(m0), 32'h00);
    check("t3_rx_data", 32'(rx_data), 32'hFF);

    // 4: abort after three bits, then a clean frame
    rx0 = rx_cnt; fe0 = ferr_cnt;
    xfer(8'hE7, 3, 1'b1, 1'b1, m0);
    check("t4_rx_cnt_abort", 32'(rx_cnt - rx0), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_rx_hold", 32'(rx_data), 32'hFF);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("t4_frame_err", 32'(ferr_cnt - fe0), 32'd1);
`endif
    xfer(8'h5A, 8, 1'b1, 1'b1, m0);
    check("t4_rx_data", 32'(rx_data), 32'h5A);
    check("t4_rx_cnt", 32'(rx_cnt - rx0), 32'd1);

    // 5: reset in the middle of a frame
    xfer(8'h0F, 5, 1'b1, 1'b0, m0);
    push(8'h99);
    check("t5_ready_full", 32'(tx_ready), 32'd0);
    rst = 1'b1; CS = 1'b1; SCLK = 1'b0;
    tick(1);
    check_reset_vals("t5_in_rst");
    tick(3);
    rst = 1'b0;
    tick(4);
    rx0 = rx_cnt;
    xfer(8'hC3, 8, 1'b1, 1'b1, m0);
    check("t5_rx_data", 32'(rx_data), 32'hC3);
    check("t5_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    check("t5_miso_idle", 32'(m0), 32'h00);

    // 6: tx_valid held while buffer is full
    push(8'h4D);
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    tick(5);
    check("t6_ready_held", 32'(tx_ready), 32'd0);
    rx0 = rx_cnt; ur0 = urun_cnt;
    fork
      begin
        xfer(8'h96, 8, 1'b1, 1'b0, m0);
        xfer(8'h69, 8, 1'b0, 1'b1, m1);
      end
      begin
        wait_ready(ok);
        check("t6_ready_after_start", 32'(ok), 32'd1);
        tick(1);
        tx_valid = 1'b0;
      end
    join
    check("t6_miso_w0", 32'(m0), 32'h4D);
    check("t6_miso_w1", 32'(m1), 32'h77);
    check("t6_underrun", 32'(urun_cnt - ur0), 32'd0);
    check("t6_rx_w0", 32'(rx_log[rx0[5:0]]), 32'h96);
    check("t6_rx_w1", 32'(rx_log[6'(rx0 + 1)]), 32'h69);
    check("t6_ready_end", 32'(tx_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
